// File: rtl/obuf_responder.sv
// obuf_responder -- 16x64 output buffer with a single memory port and a
// drain engine that streams words 0..len-1 out over a valid/ready channel.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   EN_O, RW_O          memory-port enable and direction (1 = write)
//   ADDR_O, WDATA_O     memory-port address and write data
//   RDATA_O             registered read data, holds between reads
//   DRAIN_START         one-cycle drain request, DRAIN_LEN sampled with it
//   DRAIN_LEN           words to drain from address 0 (1..16 accepted)
//   DOUT_VALID/READY    output stream handshake
//   DOUT_DATA/ADDR/LAST stream word, its source address, final-word flag
//   BUSY                drain in progress
//   WR_CNT              saturating count of port writes since reset
module obuf_responder #(
  parameter int DEPTH = 16,
  parameter int DW    = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN_O,
  input  logic          RW_O,
  input  logic [3:0]    ADDR_O,
  input  logic [DW-1:0] WDATA_O,
  output logic [DW-1:0] RDATA_O,
  input  logic          DRAIN_START,
  input  logic [4:0]    DRAIN_LEN,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic [DW-1:0] DOUT_DATA,
  output logic [3:0]    DOUT_ADDR,
  output logic          DOUT_LAST,
  output logic          BUSY,
  output logic [4:0]    WR_CNT
);

  localparam logic [4:0] MAX_LEN = 5'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] ddata_q;
  logic [3:0]    daddr_q;
  logic          dvalid_q;
  logic          dlast_q;
  logic [4:0]    len_q;
  logic [3:0]    ptr_q;
  logic [4:0]    wr_cnt_q;

  logic port_wr, port_rd;
  logic start_ok, fetch, hs;

  assign port_wr = EN_O &  RW_O;
  assign port_rd = EN_O & ~RW_O;

  // Next-state and per-cycle strobes for the drain engine.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    fetch    = 1'b0;
    hs       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (DRAIN_START && DRAIN_LEN != 5'd0 && DRAIN_LEN <= MAX_LEN) begin
          start_ok = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        // Any port access owns the memory this cycle; retry next cycle.
        if (!EN_O) begin
          fetch   = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (dvalid_q && DOUT_READY) begin
          hs      = 1'b1;
          state_d = dlast_q ? S_IDLE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (port_wr) mem_q[ADDR_O] <= WDATA_O;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdata_q  <= '0;
      ddata_q  <= '0;
      daddr_q  <= '0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      len_q    <= '0;
      ptr_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (port_rd) rdata_q <= mem_q[ADDR_O];
      if (port_wr && wr_cnt_q != 5'd31) wr_cnt_q <= wr_cnt_q + 5'd1;

      if (start_ok) begin
        len_q <= DRAIN_LEN;
        ptr_q <= '0;
      end
      // The output register snapshots the word; later port writes to the
      // same address do not disturb a word already presented.
      if (fetch) begin
        ddata_q  <= mem_q[ptr_q];
        daddr_q  <= ptr_q;
        dlast_q  <= ({1'b0, ptr_q} == len_q - 5'd1);
        dvalid_q <= 1'b1;
      end
      if (hs) begin
        dvalid_q <= 1'b0;
        dlast_q  <= 1'b0;
        if (!dlast_q) ptr_q <= ptr_q + 4'd1;
      end
    end
  end

  assign RDATA_O    = rdata_q;
  assign DOUT_VALID = dvalid_q;
  assign DOUT_DATA  = ddata_q;
  assign DOUT_ADDR  = daddr_q;
  assign DOUT_LAST  = dlast_q;
  assign BUSY       = (state_q != S_IDLE);
  assign WR_CNT     = wr_cnt_q;

endmodule

// File: tb/tb_obuf_responder.sv
// Scoreboard bench for obuf_responder: stimulus pushes expected stream beats
// and read data into queues; a negedge monitor pops and compares.
module tb_obuf_responder;
  logic        CLK = 1'b0, RST = 1'b0;
  logic        EN_O = 1'b0, RW_O = 1'b0;
  logic [3:0]  ADDR_O = '0;
  logic [63:0] WDATA_O = '0;
  logic [63:0] RDATA_O;
  logic        DRAIN_START = 1'b0;
  logic [4:0]  DRAIN_LEN = '0;
  logic        DOUT_VALID;
  logic        DOUT_READY = 1'b1;
  logic [63:0] DOUT_DATA;
  logic [3:0]  DOUT_ADDR;
  logic        DOUT_LAST, BUSY;
  logic [4:0]  WR_CNT;

  obuf_responder #(.DEPTH(16), .DW(64)) dut (
    .CLK(CLK), .RST(RST), .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O),
    .WDATA_O(WDATA_O), .RDATA_O(RDATA_O), .DRAIN_START(DRAIN_START),
    .DRAIN_LEN(DRAIN_LEN), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .DOUT_DATA(DOUT_DATA), .DOUT_ADDR(DOUT_ADDR), .DOUT_LAST(DOUT_LAST),
    .BUSY(BUSY), .WR_CNT(WR_CNT)
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Reference model: plain memory image, saturating write count, and the
  // list of beats a drain must produce.
  typedef struct packed {
    logic [3:0]  addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic [63:0] mdl_mem [16];
  int          mdl_wcnt = 0;
  bit          mdl_busy = 1'b0;
  beat_t       exp_q[$];
  logic [63:0] rd_q[$];
  int          drain_c0 = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name, string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %s", name, what);
  endfunction

  // Monitor
  bit          pv = 1'b0, pr = 1'b0, rd_pend = 1'b0;
  logic [63:0] pd;
  logic [3:0]  pa;
  logic        pl;
  always @(negedge CLK) begin
    if (RST) begin
      pv = 1'b0; rd_pend = 1'b0;
    end else begin
      if (rd_pend) begin
        if (rd_q.size() == 0) fail("rdata", "read with no expectation queued");
        else chk("rdata", RDATA_O, rd_q.pop_front());
      end
      if (pv && !pr) begin
        chk("stall_valid", 64'(DOUT_VALID), 64'd1);
        chk("stall_data", DOUT_DATA, pd);
        chk("stall_addr", 64'(DOUT_ADDR), 64'(pa));
        chk("stall_last", 64'(DOUT_LAST), 64'(pl));
      end
      if (pv && pr) chk("spacing_valid_low", 64'(DOUT_VALID), 64'd0);
      if (DOUT_VALID && DOUT_READY) begin
        if (exp_q.size() == 0) fail("dout", "beat with nothing expected");
        else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("dout_addr", 64'(DOUT_ADDR), 64'(e.addr));
          chk("dout_data", DOUT_DATA, e.data);
          chk("dout_last", 64'(DOUT_LAST), 64'(e.last));
        end
      end
      rd_pend = EN_O && !RW_O;
      pv = DOUT_VALID; pr = DOUT_READY;
      pd = DOUT_DATA;  pa = DOUT_ADDR; pl = DOUT_LAST;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic pwrite(input logic [3:0] a, input logic [63:0] d);
    EN_O = 1'b1; RW_O = 1'b1; ADDR_O = a; WDATA_O = d;
    mdl_mem[a] = d;
    if (mdl_wcnt < 31) mdl_wcnt++;
    tick();
    EN_O = 1'b0; RW_O = 1'b0;
  endtask

  task automatic pread(input logic [3:0] a);
    EN_O = 1'b1; RW_O = 1'b0; ADDR_O = a;
    rd_q.push_back(mdl_mem[a]);
    tick();
    EN_O = 1'b0;
  endtask

  task automatic drain(input int len);
    bit acc;
    acc = !mdl_busy && len >= 1 && len <= 16;
    DRAIN_START = 1'b1; DRAIN_LEN = 5'(len);
    if (acc) begin
      mdl_busy = 1'b1;
      for (int k = 0; k < len; k++)
        exp_q.push_back('{addr: 4'(k), data: mdl_mem[k], last: (k == len - 1)});
    end
    tick();
    DRAIN_START = 1'b0;
    if (acc) drain_c0 = cyc;
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n = 0;
    while (BUSY && n < 500) begin tick(); n++; end
    if (BUSY) fail(name, "timeout waiting for BUSY low");
    else if (exp_cycles >= 0) chk(name, 64'(cyc - drain_c0), 64'(exp_cycles));
    mdl_busy = 1'b0;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_addr(input logic [3:0] a);
    int n = 0;
    while (!(DOUT_VALID && DOUT_ADDR == a) && n < 100) begin tick(); n++; end
    if (n >= 100) fail("wait_valid", "timeout waiting for stream word");
  endtask

  initial begin
    int n_valid;
    int len;
    #1 RST = 1'b1;
    #1;
    chk("rst_rdata", RDATA_O, 64'd0);
    chk("rst_valid", 64'(DOUT_VALID), 64'd0);
    chk("rst_data", DOUT_DATA, 64'd0);
    chk("rst_addr", 64'(DOUT_ADDR), 64'd0);
    chk("rst_last", 64'(DOUT_LAST), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_wrcnt", 64'(WR_CNT), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Fill, read back, count writes
    for (int i = 0; i < 16; i++) pwrite(4'(i), 64'h1111_0000_0000_0000 + 64'(i));
    pread(4'd5);
    chk("wr_cnt_16", 64'(WR_CNT), 64'd16);
    pwrite(4'd9, 64'hDEAD_BEEF_0000_0009);
    pread(4'd9);
    tick();

    // Plain drain, READY held high: two cycles per word
    DOUT_READY = 1'b1;
    drain(4);
    wait_done("drain4_cycles", 8);

    // Backpressure on word 1 for five cycles
    drain(3);
    wait_addr(4'd1);
    DOUT_READY = 1'b0;
    repeat (5) tick();
    DOUT_READY = 1'b1;
    wait_done("drain3_stall_cycles", 11);

    // Port write collides with the fetch of address 2
    mdl_mem[2] = 64'hCAFE_F00D_2222_2222;
    drain(4);
    wait_addr(4'd1);
    tick();
    pwrite(4'd2, 64'hCAFE_F00D_2222_2222);
    wait_done("fetch_stall_cycles", 9);

    // Ignored requests
    drain(0);
    chk("len0_busy", 64'(BUSY), 64'd0);
    drain(17);
    chk("len17_busy", 64'(BUSY), 64'd0);
    drain(2);
    drain(5);
    wait_done("len2_cycles", 4);

    // Write counter saturation
    for (int i = 0; i < 40; i++) pwrite(4'($urandom_range(0, 15)), {$urandom, $urandom});
    chk("wr_cnt_sat", 64'(WR_CNT), 64'(mdl_wcnt));

    // Randomized drains with backpressure and port traffic
    for (int it = 0; it < 12; it++) begin
      int n = 0;
      len = $urandom_range(1, 16);
      drain(len);
      while (BUSY && n < 400) begin
        DOUT_READY = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: pread(4'($urandom_range(0, 15)));
          1: if (len < 16) pwrite(4'($urandom_range(len, 15)), {$urandom, $urandom});
             else tick();
          default: tick();
        endcase
        n++;
      end
      DOUT_READY = 1'b1;
      wait_done("rand_drain", -1);
    end

    // Reset mid-drain
    drain(8);
    repeat (3) tick();
    #2 RST = 1'b1;
    #1;
    chk("midrst_valid", 64'(DOUT_VALID), 64'd0);
    chk("midrst_data", DOUT_DATA, 64'd0);
    chk("midrst_addr", 64'(DOUT_ADDR), 64'd0);
    chk("midrst_last", 64'(DOUT_LAST), 64'd0);
    chk("midrst_busy", 64'(BUSY), 64'd0);
    chk("midrst_rdata", RDATA_O, 64'd0);
    chk("midrst_wrcnt", 64'(WR_CNT), 64'd0);
    mdl_busy = 1'b0; mdl_wcnt = 0;
    exp_q.delete(); rd_q.delete();
    #4 RST = 1'b0;
    n_valid = 0;
    repeat (20) begin tick(); if (DOUT_VALID) n_valid++; end
    chk("post_rst_no_valid", 64'(n_valid), 64'd0);
    pread(4'd0);
    pread(4'd2);
    pread(4'd15);
    tick();
    tick();
    chk("post_rst_rdq_empty", 64'(rd_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
